pipe_stage_skid: RTL

- Generic, parametrised pipeline register stage to replace the per-boundary hand-built pipe modules (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Carries an opaque data bundle and a control bundle across one stage boundary using a valid/ready handshake.
- A 2-entry skid buffer lets the upstream ready be registered, so a backpressure stall never becomes a long combinational path.
- Supports bubble insertion (nop), which masks selected control bits, and a flush that clears the stage. It also provides a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_skid.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline register stage with a 2-entry skid buffer, bubble (nop) masking,
// flush, and a saturating stall-cycle counter. Outputs come straight from the main register.
module pipe_stage_skid #(
    parameter int                DATA_W    = 64,
    parameter int                CTRL_W    = 24,
    parameter logic [CTRL_W-1:0] KILL_MASK = {CTRL_W{1'b1}},
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              nop,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    // State encoding is {skid_valid, out_valid}; 2'b10 is unreachable.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [DATA_W-1:0] out_data_r;
    logic [CTRL_W-1:0] out_ctrl_r;
    logic [DATA_W-1:0] skid_data_r;
    logic [CTRL_W-1:0] skid_ctrl_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic              accept_s;
    logic              ofire_s;
    logic              load_main_in_s;
    logic              load_main_skid_s;
    logic              load_skid_s;
    logic              clear_ctrl_s;
    logic [CTRL_W-1:0] in_ctrl_kept_s;

    assign out_valid = state_r[0];
    assign out_data  = out_data_r;
    assign out_ctrl  = out_ctrl_r;
    assign stall_cnt = stall_cnt_r;

    // Handshake qualifiers and nop masking of the incoming control bundle.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            in_ready = 1'b0;
        end else begin
            in_ready = ~state_r[1];
        end
        accept_s = in_valid & in_ready;
        ofire_s  = state_r[0] & out_ready;
        in_ctrl_kept_s = in_ctrl;
        if (nop) begin
            in_ctrl_kept_s = in_ctrl & ~KILL_MASK;
        end else begin
            in_ctrl_kept_s = in_ctrl;
        end
    end

    // Next-state and register-load decisions; flush wins over any accept.
    always_comb begin
        state_nxt_s      = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        clear_ctrl_s     = 1'b0;
        if (flush) begin
            state_nxt_s  = ST_EMPTY;
            clear_ctrl_s = 1'b1;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nxt_s    = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && ofire_s) begin
                        state_nxt_s    = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_nxt_s = ST_FULL;
                        load_skid_s = 1'b1;
                    end else if (ofire_s) begin
                        state_nxt_s  = ST_EMPTY;
                        clear_ctrl_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (ofire_s) begin
                        state_nxt_s      = ST_ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_FULL;
                    end
                end
                default: begin
                    state_nxt_s  = ST_EMPTY;
                    clear_ctrl_s = 1'b1;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Main and skid entry registers; out_data is left alone when the stage empties.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= {DATA_W{1'b0}};
            out_ctrl_r  <= {CTRL_W{1'b0}};
            skid_data_r <= {DATA_W{1'b0}};
            skid_ctrl_r <= {CTRL_W{1'b0}};
        end else begin
            if (load_main_in_s) begin
                out_data_r <= in_data;
                out_ctrl_r <= in_ctrl_kept_s;
            end else if (load_main_skid_s) begin
                out_data_r <= skid_data_r;
                out_ctrl_r <= skid_ctrl_r;
            end else if (clear_ctrl_s) begin
                out_ctrl_r <= {CTRL_W{1'b0}};
            end
            if (load_skid_s) begin
                skid_data_r <= in_data;
                skid_ctrl_r <= in_ctrl_kept_s;
            end
        end
    end

    // Saturating count of cycles where a valid output is held back; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r[0] && !out_ready && (stall_cnt_r != {CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
